// File: rtl/dedup_stream_arbiter.sv
`default_nettype none
// ============================================================================
// dedup_stream_arbiter: frame-granular round-robin sharing of one dedup
// pipeline, with an in-order ownership FIFO that steers results back.
// Revision: 1.0
// ============================================================================
module dedup_stream_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_ELEMENTS = 8,
    parameter int DATA_W       = 32,
    parameter int MAX_FRAMES   = 4,
    parameter int TAG_W        = 1 + $clog2(NUM_ELEMENTS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*NUM_ELEMENTS*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*NUM_ELEMENTS-1:0]        req_keep,
    input  logic [NUM_REQ-1:0]                     req_last,
    output logic                                   pipe_in_valid,
    input  logic                                   pipe_in_ready,
    output logic                                   pipe_in_last,
    output logic [NUM_ELEMENTS*DATA_W-1:0]         pipe_in_data,
    output logic [NUM_ELEMENTS-1:0]                pipe_in_keep,
    output logic [NUM_ELEMENTS*TAG_W-1:0]          pipe_in_tag,
    input  logic                                   pipe_out_valid,
    output logic                                   pipe_out_ready,
    input  logic                                   pipe_out_last,
    input  logic [NUM_ELEMENTS*DATA_W-1:0]         pipe_out_data,
    input  logic [NUM_ELEMENTS-1:0]                pipe_out_keep,
    input  logic [NUM_ELEMENTS*TAG_W-1:0]          pipe_out_tag,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    input  logic [NUM_REQ-1:0]                     rsp_ready,
    output logic [NUM_ELEMENTS*DATA_W-1:0]         rsp_data,
    output logic [NUM_ELEMENTS-1:0]                rsp_keep,
    output logic [NUM_ELEMENTS*TAG_W-1:0]          rsp_tag,
    output logic                                   rsp_last,
    output logic [$clog2(MAX_FRAMES):0]            frames_inflight,
    output logic                                   busy,
    output logic                                   err_orphan
);

    localparam int c_beat_w = NUM_ELEMENTS * DATA_W;
    localparam int c_req_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_ptr_w  = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam int c_cnt_w  = $clog2(MAX_FRAMES) + 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_req_w-1:0]   r_grant;
    logic [c_req_w-1:0]   r_rr;
    logic [c_req_w-1:0]   w_pick;
    logic [c_req_w-1:0]   w_cand;
    logic                 w_found;
    logic [c_req_w-1:0]   r_fifo [MAX_FRAMES];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_err_orphan;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_req_w-1:0]   w_head;

    // Round-robin search starts one past the last requester that finished a frame.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_req_w'((int'(r_rr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_full  = (r_count == c_cnt_w'(MAX_FRAMES));
    assign w_empty = (r_count == '0);
    assign w_push  = (r_state == IDLE) && w_found && !w_full;
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_pop   = pipe_out_valid && pipe_out_ready && pipe_out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = '0;
        pipe_in_valid = 1'b0;
        pipe_in_last  = 1'b0;
        pipe_in_data  = '0;
        pipe_in_keep  = '0;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                pipe_in_valid      = req_valid[r_grant];
                pipe_in_last       = req_last[r_grant];
                pipe_in_data       = req_data[int'(r_grant)*c_beat_w +: c_beat_w];
                pipe_in_keep       = req_keep[int'(r_grant)*NUM_ELEMENTS +: NUM_ELEMENTS];
                req_ready[r_grant] = pipe_in_ready;
                if (pipe_in_valid && pipe_in_ready && pipe_in_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_rr         <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_grant  <= w_pick;
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if ((r_state == LOCKED) && pipe_in_valid && pipe_in_ready && pipe_in_last) begin
                r_rr <= r_grant;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_empty && pipe_out_valid) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // Ownership storage needs no reset: entries are only read while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_pick;
        end
    end

    always_comb begin
        rsp_valid      = '0;
        pipe_out_ready = 1'b0;
        if (!w_empty) begin
            rsp_valid[w_head] = pipe_out_valid;
            pipe_out_ready    = rsp_ready[w_head];
        end
    end

    assign pipe_in_tag     = '0;
    assign rsp_data        = pipe_out_data;
    assign rsp_keep        = pipe_out_keep;
    assign rsp_tag         = pipe_out_tag;
    assign rsp_last        = pipe_out_last;
    assign frames_inflight = r_count;
    assign busy            = (r_state == LOCKED) || !w_empty;
    assign err_orphan      = r_err_orphan;

endmodule
`default_nettype wire

// File: doc/dedup_stream_arbiter.md
Name: dedup_stream_arbiter

Overview:
- Shares one deduplication pipeline (chain of dedup stages) between NUM_REQ requester streams.
- Arbitrates round-robin at frame granularity: a granted requester owns the pipeline input until its last beat.
- Records frame ownership in an in-order FIFO and routes pipeline output frames back to the owning requester.
- Sits between the per-requester vector sources and the dedup stage chain.

Parameters:
NUM_REQ, 4, number of requester streams (>=2)
NUM_ELEMENTS, 8, elements per beat
DATA_W, 32, bits per element
MAX_FRAMES, 4, ownership FIFO depth = max frames in flight inside the pipeline (power of two)
TAG_W, 1+$clog2(NUM_ELEMENTS), per-element tag width {duplicate, origin}

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accepted
req_data  in  NUM_REQ*NUM_ELEMENTS*DATA_W  per-requester beat data
req_keep  in  NUM_REQ*NUM_ELEMENTS  per-requester element keep
req_last  in  NUM_REQ  per-requester end of frame
pipe_in_valid/ready/last  out/in/out  1 each  pipeline input handshake
pipe_in_data  out  NUM_ELEMENTS*DATA_W  muxed beat data
pipe_in_keep  out  NUM_ELEMENTS  muxed keep
pipe_in_tag  out  NUM_ELEMENTS*TAG_W  always zero (clean duplicate mask)
pipe_out_valid/ready/last  in/out/in  1 each  pipeline output handshake
pipe_out_data/keep/tag  in  as pipe_in  pipeline result
rsp_valid  out  NUM_REQ  one-hot, result beat for requester i
rsp_ready  in  NUM_REQ  requester accepts result
rsp_data/keep/tag/last  out  as pipe_out  broadcast copy of pipe_out fields
frames_inflight  out  $clog2(MAX_FRAMES)+1  ownership FIFO occupancy
busy  out  1  FSM in LOCKED or FIFO non-empty
err_orphan  out  1  sticky: pipe_out_valid seen with FIFO empty

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the top level): FSM=IDLE, rr pointer=0, FIFO empty; req_ready=0, pipe_in_valid=0, rsp_valid=0, pipe_out_ready=0, frames_inflight=0, busy=0, err_orphan=0.
- FSM IDLE:
  - If any req_valid and FIFO not full, register grant = first valid index searching from (rr+1) mod NUM_REQ.
  - Push grant ID into FIFO; go to LOCKED.
  - The full check uses the current count; a same-cycle pop is not bypassed.
  - No beats pass in IDLE (req_ready all 0).
- FSM LOCKED:
  - pipe_in_{valid,data,keep,last} = req[grant].
  - req_ready[grant] = pipe_in_ready; every other req_ready = 0.
  - On pipe_in_valid && pipe_in_ready && req_last[grant]: set rr = grant, go to IDLE.
- Frame turnaround: minimum one bubble cycle between frames (IDLE grant cycle). A single-beat frame therefore occupies 2 cycles.
- Return path:
  - If FIFO non-empty with head h: rsp_valid[h] = pipe_out_valid and pipe_out_ready = rsp_ready[h]; other rsp_valid = 0.
  - Pop on pipe_out_valid && pipe_out_ready && pipe_out_last.
- Return path, FIFO empty: pipe_out_ready = 0 and rsp_valid = 0. If pipe_out_valid is high in this state, set err_orphan (sticky until reset).
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Pointer arithmetic: pointers wrap modulo MAX_FRAMES; count saturates at neither end because full/empty gate push/pop.
- Handshake rules:
  - Outputs are combinational from registered grant/FIFO head and never depend on their own ready.
  - A requester holding req_valid is never starved: round-robin guarantees a grant within NUM_REQ frames once the FIFO has space.
- Reset mid-frame: the locked frame and all FIFO entries are discarded. The pipeline must be reset in the same domain.
- pipe_in_tag is constant zero.

Test Plan:
- Req0 sends 3-beat frame, pipeline modelled as 2-cycle delay -> grant 1 cycle after req_valid; beats forwarded; rsp_valid[0] for 3 beats; frames_inflight goes 1 then 0 after the last beat.
- Req0..3 all valid with 1-beat frames continuously -> grant order 1,2,3,0,1... (rr starts 0); each frame takes exactly 2 cycles.
- MAX_FRAMES=4, pipe_out_ready path stalled (rsp_ready=0) -> 4 frames granted, then req_ready stays 0; frames_inflight=4; the 5th grant occurs the cycle after the first pop.
- pipe_in_ready toggling 1/0 during a 4-beat frame from req2 -> req_ready[2] mirrors it, no beat dropped or duplicated, no other req_ready asserted.
- pipe_out_valid asserted with FIFO empty -> pipe_out_ready=0 and err_orphan=1 persisting until rst_n low.
- rst_n asserted mid-frame while LOCKED with 2 frames in flight -> all outputs take reset values immediately; after release the next grant goes to the lowest valid index above rr=0.
